// File: rtl/acumulador_baterias_if.sv
// ---------------------------------------------------------------------------
// acumulador_baterias_if
// Bus between the battery-reading side of the lab design and the
// multi-channel accumulator.
//   master : drives start/sel/baterias, observes resultado/ocupado/listo
//   slave  : the accumulator itself
// Signals:
//   start     request a new reduction (sampled only while the block is idle)
//   sel       reduction mode: 00 sum, 01 difference, 10 max, 11 min
//   baterias  flat bus, channel i = baterias[i*WIDTH +: WIDTH]
//   resultado two's-complement result, RW bits, held between operations
//   ocupado   high while a reduction is in progress
//   listo     one-cycle pulse when resultado is updated
// ---------------------------------------------------------------------------
interface acumulador_baterias_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int RW = WIDTH + $clog2(CHANNELS) + 1;

  logic                      start;
  logic [1:0]                sel;
  logic [CHANNELS*WIDTH-1:0] baterias;
  logic [RW-1:0]             resultado;
  logic                      ocupado;
  logic                      listo;

  modport master (
    output start, sel, baterias,
    input  resultado, ocupado, listo
  );

  modport slave (
    input  start, sel, baterias,
    output resultado, ocupado, listo
  );
endinterface

// File: rtl/acumulador_baterias.sv
// ---------------------------------------------------------------------------
// acumulador_baterias
// Captures CHANNELS unsigned battery readings on a start pulse and reduces
// them one channel per clock (sum, difference, max or min). The result is
// presented on a register together with a one-cycle done pulse.
// Ports:
//   clk    single clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    acumulador_baterias_if.slave (start/sel/baterias in,
//          resultado/ocupado/listo out, all outputs registered)
// ---------------------------------------------------------------------------
module acumulador_baterias #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  acumulador_baterias_if.slave   bus
);

  localparam int RW = WIDTH + $clog2(CHANNELS) + 1;
  localparam int IW = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CHANNELS*WIDTH-1:0] r_snap;
  logic [1:0]                r_sel;
  logic [RW-1:0]             r_acc;
  logic [IW-1:0]             r_idx;
  logic [RW-1:0]             r_resultado;
  logic                      r_listo;
  logic                      r_ocupado;

  logic [WIDTH-1:0]          w_ch;
  logic [RW-1:0]             w_chExt;
  logic [RW-1:0]             w_accNext;
  logic [RW-1:0]             w_accInit;

  // Select the snapshot channel addressed by the index; an explicit mux
  // keeps the part-select bounds static.
  always_comb begin
    w_ch = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_idx == IW'(i)) begin
        w_ch = r_snap[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_chExt = {{(RW-WIDTH){1'b0}}, w_ch};

  // Min mode starts from the largest possible reading so the first channel
  // always wins; every other mode starts from zero.
  assign w_accInit = (bus.sel == 2'b11) ? {{(RW-WIDTH){1'b0}}, {WIDTH{1'b1}}} : '0;

  // One reduction step. In max/min the accumulator never exceeds WIDTH bits,
  // so comparing against its low WIDTH bits is an exact unsigned compare.
  always_comb begin
    w_accNext = r_acc;
    case (r_sel)
      2'b00:   w_accNext = r_acc + w_chExt;
      2'b01:   w_accNext = (r_idx == '0) ? (r_acc + w_chExt) : (r_acc - w_chExt);
      2'b10:   w_accNext = (w_ch > r_acc[WIDTH-1:0]) ? w_chExt : r_acc;
      default: w_accNext = (w_ch < r_acc[WIDTH-1:0]) ? w_chExt : r_acc;
    endcase
  end

  // Control FSM with registered outputs. The result register is written
  // only on the edge that enters FIN, so it holds through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_sel       <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_resultado <= '0;
      r_listo     <= 1'b0;
      r_ocupado   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_snap    <= bus.baterias;
            r_sel     <= bus.sel;
            r_idx     <= '0;
            r_acc     <= w_accInit;
            r_ocupado <= 1'b1;
            r_state   <= ACUM;
          end
        end
        ACUM: begin
          r_acc <= w_accNext;
          if (r_idx == IW'(CHANNELS-1)) begin
            r_resultado <= w_accNext;
            r_listo     <= 1'b1;
            r_state     <= FIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        FIN: begin
          r_listo   <= 1'b0;
          r_ocupado <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.resultado = r_resultado;
  assign bus.listo     = r_listo;
  assign bus.ocupado   = r_ocupado;

endmodule

// File: tb/tb_acumulador_baterias.sv
// ---------------------------------------------------------------------------
// tb_acumulador_baterias
// Directed bench for acumulador_baterias with WIDTH=8, CHANNELS=4 (RW=11).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_acumulador_baterias;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  acumulador_baterias_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  acumulador_baterias #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drive the bus inputs on the current falling edge.
  task automatic applyStimulus(input logic s, input logic [1:0] m, input logic [31:0] b);
    bus.start    = s;
    bus.sel      = m;
    bus.baterias = b;
  endtask

  // Full operation: one start pulse, then watch six cycles for the listo
  // pulse position, listo width and ocupado width, then check the result.
  task automatic runOp(input logic [1:0] m, input logic [31:0] b, input logic [10:0] exp, input string tag);
    int busyCycles;
    int listoCycles;
    int listoAt;
    @(negedge clk);
    applyStimulus(1'b1, m, b);
    @(negedge clk);
    applyStimulus(1'b0, m, b);
    busyCycles  = 0;
    listoCycles = 0;
    listoAt     = -1;
    for (int i = 0; i < 6; i++) begin
      if (bus.ocupado === 1'b1) busyCycles++;
      if (bus.listo === 1'b1) begin
        listoCycles++;
        listoAt = i;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_resultado"}, {21'd0, bus.resultado}, {21'd0, exp});
    checkOutput({tag, "_listoWidth"}, listoCycles, 1);
    checkOutput({tag, "_listoLatency"}, listoAt, 4);
    checkOutput({tag, "_ocupadoWidth"}, busyCycles, 5);
  endtask

  initial begin
    int listoCount;
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 2'b00, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_resultado", {21'd0, bus.resultado}, 32'd0);
    checkOutput("reset_listo", {31'd0, bus.listo}, 32'd0);
    checkOutput("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Sum at full scale: 4 * 255
    runOp(2'b00, 32'hFFFF_FFFF, 11'd1020, "sum_full");
    // Difference worst case: 0 - 3*255 = -765
    runOp(2'b01, 32'hFFFF_FF00, 11'h503, "diff_worst");
    // Difference best case: 255 - 0
    runOp(2'b01, 32'h0000_00FF, 11'd255, "diff_best");
    // Channels {6,13,80,65}
    runOp(2'b10, 32'h4150_0D06, 11'd80, "max");
    runOp(2'b11, 32'h4150_0D06, 11'd6, "min");
    runOp(2'b00, 32'h4150_0D06, 11'd164, "sum_mixed");
    // Extremes: min of all-max readings, max of all-zero readings
    runOp(2'b11, 32'hFFFF_FFFF, 11'd255, "min_allones");
    runOp(2'b10, 32'h0000_0000, 11'd0, "max_zero");

    // Start while busy and input change after the snapshot
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 32'h0102_0304);
    @(negedge clk);
    applyStimulus(1'b0, 2'b11, 32'h0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'b11, 32'h0);
    @(negedge clk);
    checkOutput("busy_listo", {31'd0, bus.listo}, 32'd1);
    checkOutput("busy_resultado", {21'd0, bus.resultado}, 32'd10);
    listoCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.listo === 1'b1) listoCount++;
    end
    checkOutput("busy_noSecondListo", listoCount, 0);
    checkOutput("busy_resultadoHeld", {21'd0, bus.resultado}, 32'd10);

    // Reset in the middle of a reduction
    applyStimulus(1'b1, 2'b00, 32'h4150_0D06);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h4150_0D06);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_ocupadoBefore", {31'd0, bus.ocupado}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_resultado", {21'd0, bus.resultado}, 32'd0);
    checkOutput("midrst_listo", {31'd0, bus.listo}, 32'd0);
    checkOutput("midrst_ocupado", {31'd0, bus.ocupado}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    listoCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.listo === 1'b1 || bus.ocupado === 1'b1) listoCount++;
    end
    checkOutput("midrst_staysIdle", listoCount, 0);
    runOp(2'b00, 32'h4150_0D06, 11'd164, "after_rst");

    // Result hold with toggling inputs and start low
    listoCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'(i), (i % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);
      @(negedge clk);
      if (bus.listo === 1'b1) listoCount++;
      checkOutput("hold_resultado", {21'd0, bus.resultado}, 32'd164);
    end
    checkOutput("hold_listo", listoCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/acumulador_baterias.md
# acumulador_baterias

Parametrised, multi-channel successor to the lab's battery adder. It captures CHANNELS unsigned battery readings of WIDTH bits on a start pulse. It then reduces them one channel per clock in a mode chosen by `sel`: sum, difference, maximum or minimum. It presents a registered result with a done pulse, and sits between the battery-reading bus and the display/decision logic of the lab design.

## Interface
- `WIDTH`, default 8: bits per battery reading, ≥ 1.
- `CHANNELS`, default 4: number of readings, ≥ 2.
- `RW` (localparam) = WIDTH + $clog2(CHANNELS) + 1: result width, two's complement.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new reduction; sampled only in IDLE.
- `sel`  in  2: mode, latched with `start`.
  - 00: sum of all channels.
  - 01: ch0 minus the sum of ch1..ch(CHANNELS-1).
  - 10: maximum.
  - 11: minimum.
- `baterias`  in  CHANNELS*WIDTH: flat reading bus; channel i = `baterias[i*WIDTH +: WIDTH]`.
- `resultado`  out  RW: final value, two's complement; held between operations.
- `ocupado`  out  1: high while a reduction is in progress (ACUM or FIN).
- `listo`  out  1: one-cycle pulse when `resultado` is updated.

## Operation
- **FSM states:** IDLE, ACUM, FIN. Reset enters IDLE.
- **Reset values:**
  - `resultado` = 0, `listo` = 0, `ocupado` = 0.
  - Snapshot, accumulator and index registers = 0.
- **IDLE, `start` = 1:**
  - Snapshot all of `baterias` and latch `sel`.
  - Set index = 0 and go to ACUM.
  - Accumulator initial value by mode: 0 for modes 00/01; 0 for max; all-ones (2^WIDTH − 1) for min.
- **IDLE, `start` = 0:** stay in IDLE; nothing changes.
- **ACUM:** each cycle consumes snapshot channel `idx`.
  - Mode 00: acc += ch.
  - Mode 01: acc += ch if idx = 0, else acc −= ch.
  - Mode 10: acc = ch if ch > acc.
  - Mode 11: acc = ch if ch < acc.
  - Comparisons are unsigned on WIDTH bits. Ties keep acc, with identical value either way.
- **ACUM exit:** when idx = CHANNELS−1, write the final value to `resultado`, set `listo` = 1 and go to FIN. Otherwise increment idx.
- **FIN:** clear `listo` and go to IDLE.
- **Input handling:**
  - `start` is ignored in ACUM and FIN; there is no queuing.
  - Changes on `baterias` or `sel` after the snapshot do not affect the running operation.
- **Arithmetic:** all arithmetic is RW bits wide, so no overflow is possible.
  - Mode 00 range: 0 .. CHANNELS·(2^WIDTH−1).
  - Mode 01 range: −(CHANNELS−1)·(2^WIDTH−1) .. 2^WIDTH−1.
  - Modes 10/11: zero-extended readings.
- **Result hold:** `resultado` changes only on the FIN-entry edge, and stays stable through IDLE until the next completion.

## Timing
- `start` sampled high at edge k:
  - ACUM runs from edge k+1 to edge k+CHANNELS.
  - `resultado` and `listo` update at edge k+CHANNELS.
  - `listo` is high for exactly one cycle, between edges k+CHANNELS and k+CHANNELS+1.
- Latency from the sampling edge to valid `resultado` is CHANNELS clocks.
- Back-to-back operation: a `start` held high re-triggers on the edge that samples IDLE, i.e. edge k+CHANNELS+2. Throughput is one reduction per CHANNELS+2 clocks.
- `ocupado` is high from edge k to edge k+CHANNELS+1.
- Reset asserted mid-operation:
  - All outputs clear immediately, asynchronously; the partial result is discarded.
  - After `rst_n` deasserts, the FSM is in IDLE and waits for a fresh `start`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
(WIDTH=8, CHANNELS=4, RW=11)
- **Sum, full scale:** all channels 255, sel=00, start → after 4 clocks `resultado`=1020, `listo` pulse of width 1, `ocupado` high for 5 cycles.
- **Difference, worst case:** ch0=0, ch1..3=255, sel=01 → `resultado`=11'h503 (−765). Then ch0=255, others 0 → `resultado`=255.
- **Max/min:** channels {6,13,80,65}. sel=10 → 80; sel=11 → 6; sel=00 → 164.
- **Start while busy, input change ignored:** pulse `start` again 2 cycles into a sum, and change `baterias` to all-zero on the cycle after the start edge → first result unchanged, no second `listo` until a start is sampled in IDLE.
- **Reset mid-operation:** drop `rst_n` at cycle 2 of ACUM → `resultado`=0, `listo`=0, `ocupado`=0 immediately. Release and restart → correct result 4 clocks after the new start.
- **Result hold:** after completion, hold `start`=0 for 10 cycles with `baterias` toggling → `resultado` constant, `listo` stays 0.
